// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-port arbiter, command sequencer and zero-fill engine for one single-port ram
module ram_port_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 16,
    parameter int CLEAR_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  ram_cs,
    output logic                  ram_web
);
    typedef enum logic {SERVE, CLEAR} state_t;

    // One extra bit so a full-depth clear never wraps before its last word
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(CLEAR_DEPTH - 1);

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  cs_q, cs_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  tag_rd_q, tag_rd_d;
    logic                  tag_b_q, tag_b_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  clr_done_q, clr_done_d;
    logic                  serve;
    logic                  clearing;
    logic                  cnt_last;

    // Grant decision: a clear request blocks grants; on contention rr_q=1 favours B
    always_comb begin
        serve = (state_q == SERVE) && !clr_start;
        a_gnt = serve && a_req && (!b_req || !rr_q);
        b_gnt = serve && b_req && (!a_req || rr_q);
    end

    // Next-state, registered ram command, read tag and read-return capture
    always_comb begin
        clearing   = (state_q == CLEAR);
        cnt_last   = clearing && (cnt_q == CNT_LAST);
        state_d    = clearing ? (cnt_last ? SERVE : CLEAR) : (clr_start ? CLEAR : SERVE);
        cnt_d      = (clearing && !cnt_last) ? cnt_q + 1'b1 : '0;
        clr_done_d = cnt_last;
        rr_d       = a_gnt ? 1'b1 : b_gnt ? 1'b0 : rr_q;
        cs_d       = clearing || a_gnt || b_gnt;
        web_d      = clearing ? 1'b0 : a_gnt ? !a_we : b_gnt ? !b_we : 1'b1;
        addr_d     = clearing ? cnt_q[ADDR_WIDTH-1:0] : a_gnt ? a_addr : b_gnt ? b_addr : addr_q;
        wd_d       = clearing ? '0 : a_gnt ? a_wdata : b_gnt ? b_wdata : wd_q;
        tag_rd_d   = (a_gnt && !a_we) || (b_gnt && !b_we);
        tag_b_d    = b_gnt;
        a_rvalid_d = tag_rd_q && !tag_b_q;
        b_rvalid_d = tag_rd_q && tag_b_q;
        a_rdata_d  = a_rvalid_d ? ram_q : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? ram_q : b_rdata_q;
    end

    // All state, including the SERVE/CLEAR FSM, with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SERVE;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            cs_q       <= 1'b0;
            web_q      <= 1'b1;
            addr_q     <= '0;
            wd_q       <= '0;
            tag_rd_q   <= 1'b0;
            tag_b_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            tag_rd_q   <= tag_rd_d;
            tag_b_q    <= tag_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign ram_cs      = cs_q;
    assign ram_web     = web_q;
    assign ram_address = addr_q;
    assign ram_d       = wd_q;
    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign clr_busy    = (state_q == CLEAR);
    assign clr_done    = clr_done_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scoreboard bench for ram_port_arbiter with an attached ram model
module tb_ram_port_arbiter;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, clr_start = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, clr_busy, clr_done, ram_cs, ram_web;
    logic [DW-1:0] a_rdata, b_rdata, ram_d, ram_q;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] mem [16];

    int vectors = 0;
    int miscompares = 0;
    bit push_en = 1'b1;
    logic [DW:0] sb [$];

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_address(ram_address), .ram_d(ram_d), .ram_q(ram_q),
        .ram_cs(ram_cs), .ram_web(ram_web)
    );

    always #5 clk = ~clk;

    // Single-port ram: write on edge, asynchronous read
    always @(posedge clk) if (ram_cs && !ram_web) mem[ram_address] <= ram_d;
    assign ram_q = ram_cs ? mem[ram_address] : '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected response
    always @(negedge clk) begin
        logic [DW:0] e;
        if (a_rvalid && b_rvalid) chk("dual_rvalid", 1, 0);
        else if (a_rvalid || b_rvalid) begin
            if (sb.size() == 0) chk("unexpected_rvalid", {31'd0, b_rvalid}, 32'hdead);
            else begin
                e = sb.pop_front();
                chk("rvalid_port", {31'd0, b_rvalid}, {31'd0, e[DW]});
                chk("rdata", b_rvalid ? b_rdata : a_rdata, e[DW-1:0]);
            end
        end
    end

    task automatic tick(input logic ega, input logic egb, input logic [DW-1:0] eda,
                        input logic [DW-1:0] edb, input logic ebusy, input logic edone);
        @(negedge clk);
        chk("a_gnt", a_gnt, ega);
        chk("b_gnt", b_gnt, egb);
        chk("clr_busy", clr_busy, ebusy);
        chk("clr_done", clr_done, edone);
        if (push_en && ega && !a_we) sb.push_back({1'b0, eda});
        if (push_en && egb && !b_we) sb.push_back({1'b1, edb});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst();
        chk("rst_cs", ram_cs, 0);
        chk("rst_web", ram_web, 1);
        chk("rst_addr", ram_address, 0);
        chk("rst_d", ram_d, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);
    endtask

    task automatic idle(input int n);
        a_req = 0;
        b_req = 0;
        clr_start = 0;
        repeat (n) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        a_req = 0;
        b_req = 0;
        clr_start = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        chk_rst();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        // Preload mem[i] = 0x1000+i through port A
        a_req = 1; a_we = 1;
        for (int i = 0; i < 16; i++) begin
            a_addr = AW'(i); a_wdata = 16'h1000 + DW'(i);
            tick(1, 0, 0, 0, 0, 0);
        end
        // 1: write then read-after-write on A
        a_addr = 5; a_wdata = 16'hBEEF;
        tick(1, 0, 0, 0, 0, 0);
        a_we = 0;
        tick(1, 0, 16'hBEEF, 0, 0, 0);
        idle(3);
        // 2: contention from reset A,B,A, idle, then B (pointer held while idle)
        do_reset();
        a_req = 1; a_we = 0; a_addr = 1; b_req = 1; b_we = 0; b_addr = 9;
        tick(1, 0, 16'h1001, 0, 0, 0);
        tick(0, 1, 0, 16'h1009, 0, 0);
        tick(1, 0, 16'h1001, 0, 0, 0);
        idle(2);
        a_req = 1; b_req = 1;
        tick(0, 1, 0, 16'h1009, 0, 0);
        idle(3);
        // 3: B back-to-back reads 0..7
        b_req = 1;
        for (int i = 0; i < 8; i++) begin
            b_addr = AW'(i);
            tick(0, 1, 0, (i == 5) ? 16'hBEEF : 16'h1000 + DW'(i), 0, 0);
        end
        idle(3);
        // 4: fill with FFFF, clear with simultaneous a_req, read back zeros
        a_req = 1; a_we = 1; a_wdata = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            a_addr = AW'(i);
            tick(1, 0, 0, 0, 0, 0);
        end
        a_we = 0; a_addr = 3; clr_start = 1;
        tick(0, 0, 0, 0, 0, 0);
        clr_start = 0;
        repeat (16) tick(0, 0, 0, 0, 1, 0);
        a_req = 0;
        tick(0, 0, 0, 0, 0, 1);
        b_req = 1;
        for (int i = 0; i < 16; i++) begin
            b_addr = AW'(i);
            tick(0, 1, 0, 0, 0, 0);
        end
        idle(3);
        // 5: read in flight into a clear; clr_start during busy ignored
        a_req = 1; a_we = 1; a_addr = 2; a_wdata = 16'h1234;
        tick(1, 0, 0, 0, 0, 0);
        a_req = 0; b_req = 1; b_addr = 2;
        tick(0, 1, 0, 16'h1234, 0, 0);
        b_req = 0; clr_start = 1;
        tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            clr_start = (i == 2);
            tick(0, 0, 0, 0, 1, 0);
        end
        clr_start = 0;
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0);
        idle(2);
        // 6a: reset mid-clear
        clr_start = 1;
        tick(0, 0, 0, 0, 0, 0);
        clr_start = 0;
        repeat (4) tick(0, 0, 0, 0, 1, 0);
        rst_n = 0;
        #1;
        chk_rst();
        @(posedge clk);
        #1;
        rst_n = 1;
        idle(20);
        // 6b: reset with an A read in flight; then contention must favour A
        a_req = 1; a_we = 0; a_addr = 1; a_wdata = 16'hA5A5; push_en = 0;
        tick(1, 0, 0, 0, 0, 0);
        a_req = 0;
        rst_n = 0;
        #1;
        chk_rst();
        @(posedge clk);
        #1;
        rst_n = 1;
        push_en = 1;
        idle(3);
        a_req = 1; b_req = 1; b_addr = 4;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        idle(4);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
